// File: rtl/n25q_spi_responder_if.sv
// SPI pin bundle between a flash master and the N25Q responder model.
interface n25q_spi_responder_if;
    logic sclk;
    logic csb;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, csb, mosi, input miso, miso_oe);
    modport slave  (input sclk, csb, mosi, output miso, miso_oe);
endinterface

// File: rtl/n25q_spi_responder.sv
// N25Q SPI flash responder (mode 0): oversamples the SPI pins in the ifclk domain and
// serves WREN/WRDI/RDSR/RDID/READ/PP from an internal byte array.
module n25q_spi_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          PROG_CYCLES = 64,
    parameter logic [23:0] ID_BYTES    = 24'h20BA18
) (
    input  logic                 ifclk,
    input  logic                 resetb,
    n25q_spi_responder_if.slave  spi,
    output logic                 wel,
    output logic                 wip,
    output logic [7:0]           last_cmd
);
    localparam int CNT_W = $clog2(PROG_CYCLES + 1);

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, PP_DATA, STATUS, ID, IGNORE} state_t;
    state_t state_q, state_d;

    logic [1:0]            sclk_sync, csb_sync, mosi_sync;
    logic                  sclk_prev, csb_prev;
    logic                  sclk_rise, sclk_fall, csb_rise, csb_fall, mosi_s;
    logic [4:0]            bit_cnt;
    logic [2:0]            tx_cnt;
    logic [1:0]            id_idx;
    logic [ADDR_WIDTH-2:0] shift_q;
    logic [ADDR_WIDTH-1:0] rx_addr, addr;
    logic [7:0]            rx_byte, cur_byte, tx_q, mem_inv_q;
    logic [CNT_W-1:0]      prog_cnt;
    logic                  wel_set_pend, wel_clr_pend, pp_wrote, mem_we, out_state;

    // Stored inverted so the power-up value of zero reads back as erased 0xFF.
    logic [7:0] mem_inv [2**ADDR_WIDTH];

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            sclk_sync <= 2'b00;
            csb_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            csb_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.sclk};
            csb_sync  <= {csb_sync[0], spi.csb};
            mosi_sync <= {mosi_sync[0], spi.mosi};
            sclk_prev <= sclk_sync[1];
            csb_prev  <= csb_sync[1];
        end
    end

    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign csb_rise  = csb_sync[1] & ~csb_prev;
    assign csb_fall  = ~csb_sync[1] & csb_prev;
    assign rx_addr   = {shift_q, mosi_s};
    assign rx_byte   = rx_addr[7:0];
    assign out_state = (state_q == RD_DATA) || (state_q == STATUS) || (state_q == ID);
    assign mem_we    = sclk_rise && !csb_rise && (state_q == PP_DATA) && (bit_cnt == 5'd7);

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (csb_rise) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (csb_fall) state_d = CMD;
        end else if (sclk_rise) begin
            case (state_q)
                CMD: begin
                    if (bit_cnt == 5'd7) begin
                        if (wip && rx_byte != OP_RDSR) begin
                            state_d = IGNORE;
                        end else begin
                            case (rx_byte)
                                OP_RDSR: state_d = STATUS;
                                OP_RDID: state_d = ID;
                                OP_READ: state_d = ADDR;
                                OP_PP:   state_d = wel ? ADDR : IGNORE;
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: if (bit_cnt == 5'd23) state_d = (last_cmd == OP_PP) ? PP_DATA : RD_DATA;
                default: ;
            endcase
        end
    end

    // Byte presented at the start of each output byte; status is sampled live.
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            STATUS:  cur_byte = {6'b0, wel, wip};
            RD_DATA: cur_byte = ~mem_inv_q;
            ID: begin
                case (id_idx)
                    2'd0:    cur_byte = ID_BYTES[23:16];
                    2'd1:    cur_byte = ID_BYTES[15:8];
                    2'd2:    cur_byte = ID_BYTES[7:0];
                    default: cur_byte = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    // Programming can only clear bits, which in the inverted store means setting them.
    always_ff @(posedge ifclk) begin
        if (mem_we) mem_inv[addr] <= mem_inv_q | ~rx_byte;
        mem_inv_q <= mem_inv[addr];
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            spi.miso     <= 1'b0;
            spi.miso_oe  <= 1'b0;
            wel          <= 1'b0;
            wip          <= 1'b0;
            last_cmd     <= 8'h00;
            bit_cnt      <= '0;
            tx_cnt       <= '0;
            id_idx       <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            addr         <= '0;
            prog_cnt     <= '0;
            wel_set_pend <= 1'b0;
            wel_clr_pend <= 1'b0;
            pp_wrote     <= 1'b0;
        end else begin
            if (wip) begin
                if (prog_cnt <= CNT_W'(1)) begin
                    wip      <= 1'b0;
                    prog_cnt <= '0;
                end else begin
                    prog_cnt <= prog_cnt - CNT_W'(1);
                end
            end
            if (csb_rise) begin
                bit_cnt      <= '0;
                tx_cnt       <= '0;
                spi.miso     <= 1'b0;
                spi.miso_oe  <= 1'b0;
                wel_set_pend <= 1'b0;
                wel_clr_pend <= 1'b0;
                pp_wrote     <= 1'b0;
                if (wel_set_pend) wel <= 1'b1;
                if (wel_clr_pend) wel <= 1'b0;
                if (pp_wrote) begin
                    wel      <= 1'b0;
                    wip      <= 1'b1;
                    prog_cnt <= CNT_W'(PROG_CYCLES);
                end
            end else if (csb_fall) begin
                bit_cnt <= '0;
                tx_cnt  <= '0;
                id_idx  <= '0;
            end else if (sclk_rise) begin
                shift_q <= rx_addr[ADDR_WIDTH-2:0];
                bit_cnt <= bit_cnt + 5'd1;
                case (state_q)
                    CMD: begin
                        if (bit_cnt == 5'd7) begin
                            bit_cnt  <= '0;
                            last_cmd <= rx_byte;
                            if (!wip) begin
                                wel_set_pend <= (rx_byte == OP_WREN);
                                wel_clr_pend <= (rx_byte == OP_WRDI);
                            end
                        end
                    end
                    ADDR: begin
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            addr    <= rx_addr;
                        end
                    end
                    PP_DATA: begin
                        if (bit_cnt == 5'd7) begin
                            bit_cnt    <= '0;
                            pp_wrote   <= 1'b1;
                            addr[7:0]  <= addr[7:0] + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (sclk_fall && out_state) begin
                spi.miso_oe <= 1'b1;
                tx_cnt      <= tx_cnt + 3'd1;
                if (tx_cnt == 3'd0) begin
                    spi.miso <= cur_byte[7];
                    tx_q     <= {cur_byte[6:0], 1'b0};
                    if (state_q == RD_DATA) addr <= addr + ADDR_WIDTH'(1);
                    if (state_q == ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                end else begin
                    spi.miso <= tx_q[7];
                    tx_q     <= {tx_q[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_n25q_spi_responder.sv
// Scoreboard bench for n25q_spi_responder: a bit-banged SPI master plus a byte-array
// reference model that predicts every byte read back.
module tb_n25q_spi_responder;
    localparam int ADDR_WIDTH  = 12;
    localparam int PROG_CYCLES = 800;
    localparam int HALF        = 8;
    localparam int MEM_SIZE    = 1 << ADDR_WIDTH;

    logic       ifclk = 1'b0;
    logic       resetb;
    logic       wel, wip;
    logic [7:0] last_cmd;

    n25q_spi_responder_if bus();

    n25q_spi_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PROG_CYCLES(PROG_CYCLES),
        .ID_BYTES   (24'h20BA18)
    ) dut (
        .ifclk   (ifclk),
        .resetb  (resetb),
        .spi     (bus),
        .wel     (wel),
        .wip     (wip),
        .last_cmd(last_cmd)
    );

    always #5 ifclk = ~ifclk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [MEM_SIZE];
    logic       model_wel;
    logic [7:0] exp_q[$];
    logic [7:0] pp_data[$];
    int         wip_runs[$];
    int         wip_run = 0;
    bit         oe_seen = 1'b0;

    // Records each contiguous wip-high run length and whether miso_oe ever rose.
    always @(negedge ifclk) begin
        if (bus.miso_oe) oe_seen = 1'b1;
        if (wip) begin
            wip_run++;
        end else if (wip_run != 0) begin
            wip_runs.push_back(wip_run);
            wip_run = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ifclk);
    endtask

    task automatic spi_select();
        bus.csb = 1'b0;
        tick(HALF);
    endtask

    task automatic spi_deselect();
        tick(HALF);
        bus.csb = 1'b1;
        tick(3 * HALF);
    endtask

    task automatic send_bits(input logic [7:0] tx, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.mosi = tx[i];
            tick(HALF);
            bus.sclk = 1'b1;
            tick(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bus.mosi = tx[i];
            tick(HALF);
            rx[i] = bus.miso;
            bus.sclk = 1'b1;
            tick(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] rx;
        applyStimulus(a[23:16], rx);
        applyStimulus(a[15:8], rx);
        applyStimulus(a[7:0], rx);
    endtask

    task automatic send_cmd(input logic [7:0] op);
        logic [7:0] rx;
        spi_select();
        applyStimulus(op, rx);
        spi_deselect();
        if (op == 8'h06) model_wel = 1'b1;
        if (op == 8'h04) model_wel = 1'b0;
    endtask

    task automatic read_check(input string tag, input int n);
        logic [7:0] rx;
        for (int i = 0; i < n; i++) begin
            applyStimulus(8'h00, rx);
            if (exp_q.size() == 0) checkOutput({tag, "_missing"}, 32'd1, 32'd0);
            else                   checkOutput(tag, {24'h0, rx}, {24'h0, exp_q.pop_front()});
        end
    endtask

    task automatic do_read(input int a, input int n, input string tag);
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(a + i) % MEM_SIZE]);
        spi_select();
        begin
            logic [7:0] rx;
            applyStimulus(8'h03, rx);
        end
        send_addr(24'(a));
        read_check(tag, n);
        spi_deselect();
    endtask

    task automatic do_pp(input int a);
        logic [7:0] rx;
        int         ma;
        ma = a % MEM_SIZE;
        if (model_wel) begin
            foreach (pp_data[i]) begin
                ref_mem[ma] = ref_mem[ma] & pp_data[i];
                ma = (ma & ~32'hFF) | ((ma + 1) & 32'hFF);
            end
            if (pp_data.size() > 0) model_wel = 1'b0;
        end
        spi_select();
        applyStimulus(8'h02, rx);
        send_addr(24'(a));
        foreach (pp_data[i]) applyStimulus(pp_data[i], rx);
        spi_deselect();
    endtask

    task automatic wait_prog(input string tag);
        int n = 0;
        while (wip && n < 4 * PROG_CYCLES) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_wip_timeout"}, {31'h0, wip}, 32'd0);
        tick(2);
        if (wip_runs.size() == 0) checkOutput({tag, "_wip_run_missing"}, 32'd0, 32'd1);
        else                      checkOutput({tag, "_wip_len"}, wip_runs.pop_front(), PROG_CYCLES);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'hFF;
        model_wel = 1'b0;
        bus.sclk  = 1'b0;
        bus.csb   = 1'b1;
        bus.mosi  = 1'b0;
        resetb    = 1'b0;
        tick(5);
        resetb = 1'b1;
        tick(5);
        checkOutput("rst_miso", {31'h0, bus.miso}, 32'd0);
        checkOutput("rst_miso_oe", {31'h0, bus.miso_oe}, 32'd0);
        checkOutput("rst_wel", {31'h0, wel}, 32'd0);
        checkOutput("rst_wip", {31'h0, wip}, 32'd0);
        checkOutput("rst_last_cmd", {24'h0, last_cmd}, 32'h00);

        // READ ID: three ID bytes then zeros.
        exp_q.push_back(8'h20);
        exp_q.push_back(8'hBA);
        exp_q.push_back(8'h18);
        exp_q.push_back(8'h00);
        spi_select();
        applyStimulus(8'h9F, rx);
        read_check("rdid", 4);
        spi_deselect();
        checkOutput("rdid_last_cmd", {24'h0, last_cmd}, 32'h9F);
        checkOutput("rdid_oe_after", {31'h0, bus.miso_oe}, 32'd0);
        checkOutput("rdid_miso_after", {31'h0, bus.miso}, 32'd0);

        pp_data = {};
        pp_data.push_back(8'h00);
        do_pp(32'h10);
        checkOutput("pp_nowren_wel", {31'h0, wel}, 32'd0);
        checkOutput("pp_nowren_wip", {31'h0, wip}, 32'd0);
        do_read(32'h10, 1, "pp_nowren_rd");

        send_cmd(8'h06);
        checkOutput("wren_wel", {31'h0, wel}, {31'h0, model_wel});
        send_cmd(8'h04);
        checkOutput("wrdi_wel", {31'h0, wel}, {31'h0, model_wel});

        // Page program crossing the page boundary wraps back to 0x000.
        send_cmd(8'h06);
        pp_data = {};
        pp_data.push_back(8'h12);
        pp_data.push_back(8'h34);
        pp_data.push_back(8'h56);
        do_pp(32'hFE);
        checkOutput("pp_wrap_wel", {31'h0, wel}, 32'd0);
        checkOutput("pp_wrap_wip", {31'h0, wip}, 32'd1);
        wait_prog("pp_wrap");
        do_read(32'hFE, 2, "pp_wrap_rd_fe");
        do_read(32'h000, 1, "pp_wrap_rd_00");

        // Status polling and a rejected READ while the program is still running.
        send_cmd(8'h06);
        pp_data = {};
        pp_data.push_back(8'hA5);
        do_pp(32'h20);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        spi_select();
        applyStimulus(8'h05, rx);
        read_check("rdsr_busy", 2);
        spi_deselect();
        oe_seen = 1'b0;
        exp_q.push_back(8'h00);
        spi_select();
        applyStimulus(8'h03, rx);
        send_addr(24'h000020);
        read_check("read_busy", 1);
        spi_deselect();
        checkOutput("read_busy_oe", {31'h0, oe_seen}, 32'd0);
        checkOutput("read_busy_last_cmd", {24'h0, last_cmd}, 32'h03);
        wait_prog("rdsr");
        exp_q.push_back(8'h00);
        spi_select();
        applyStimulus(8'h05, rx);
        read_check("rdsr_idle", 1);
        spi_deselect();
        do_read(32'h20, 1, "pp_a5_rd");

        send_cmd(8'h06);
        pp_data = {};
        pp_data.push_back(8'hF0);
        do_pp(32'h40);
        wait_prog("and1");
        send_cmd(8'h06);
        pp_data = {};
        pp_data.push_back(8'h3C);
        do_pp(32'h40);
        wait_prog("and2");
        do_read(32'h40, 1, "and_rd");

        do_read(MEM_SIZE - 1, 2, "rd_wrap");

        // csb rises halfway through the second data byte: only the first byte lands.
        send_cmd(8'h06);
        spi_select();
        applyStimulus(8'h02, rx);
        send_addr(24'h000080);
        applyStimulus(8'h00, rx);
        send_bits(8'h00, 4);
        spi_deselect();
        ref_mem[32'h80] = 8'h00;
        model_wel = 1'b0;
        wait_prog("abort");
        do_read(32'h80, 2, "abort_rd");

        // Reset in the middle of a program keeps the array but clears control state.
        send_cmd(8'h06);
        checkOutput("rstpp_wel_pre", {31'h0, wel}, 32'd1);
        spi_select();
        applyStimulus(8'h02, rx);
        send_addr(24'h000090);
        applyStimulus(8'h0F, rx);
        send_bits(8'h00, 4);
        resetb = 1'b0;
        tick(3);
        checkOutput("rstpp_wel", {31'h0, wel}, 32'd0);
        checkOutput("rstpp_wip", {31'h0, wip}, 32'd0);
        checkOutput("rstpp_miso_oe", {31'h0, bus.miso_oe}, 32'd0);
        checkOutput("rstpp_last_cmd", {24'h0, last_cmd}, 32'h00);
        bus.csb = 1'b1;
        tick(4);
        resetb = 1'b1;
        tick(10);
        ref_mem[32'h90] = 8'h0F;
        model_wel = 1'b0;
        do_read(32'h90, 2, "rstpp_rd");
        checkOutput("rstpp_wel_post", {31'h0, wel}, 32'd0);

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/n25q_spi_responder.md
# n25q_spi_responder

Synthesizable SPI flash responder that emulates the N25Q command subset used by the team's SPI flash controller, so the controller can be exercised end-to-end in simulation and on boards without a physical flash part. It oversamples sclk, csb and mosi in the ifclk domain and decodes commands. It backs reads and page programs with an internal byte array, and drives miso in SPI mode 0.

## Interface
Parameters:
- ADDR_WIDTH, 12: byte-address width of the internal array (2^ADDR_WIDTH bytes).
- PROG_CYCLES, 64: ifclk cycles WIP stays set after a page program ends.
- ID_BYTES, 24'h20BA18: manufacturer/type/capacity returned by READ ID, MSB first.

Ports:
- ifclk  in  1  system clock; all logic is synchronous to it.
- resetb  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from the master, asynchronous to ifclk.
- csb  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  high while a read-type command is in its data phase.
- wel  out  1  write-enable latch (status bit 1).
- wip  out  1  write-in-progress (status bit 0).
- last_cmd  out  8  opcode of the most recent command accepted.

The reset is resetb: asynchronous, active-low. The clock is ifclk.

## Operation
- sclk, csb and mosi each pass through a 2-flop synchronizer. Edges are detected on the synchronized sclk. Mode 0 only: mosi is sampled on sclk rise, and miso changes on sclk fall.
- A csb rising edge at any point aborts the transaction and discards any partial byte. The state returns to IDLE. The bit counter clears.
- A csb falling edge moves IDLE -> CMD.
- States: IDLE, CMD, ADDR, RD_DATA, PP_DATA, STATUS, ID, IGNORE.
- CMD: collect 8 bits MSB first. On the 8th rise, set last_cmd and dispatch:
  - 0x06 WREN: set wel at csb rise. Next state IGNORE.
  - 0x04 WRDI: clear wel at csb rise. Next state IGNORE.
  - 0x05 RDSR: next state STATUS. Stream {6'b0, wel, wip}, repeated every byte.
  - 0x9F RDID: next state ID. Stream the 3 ID_BYTES, then 0x00 forever.
  - 0x03 READ: next state ADDR, then RD_DATA.
  - 0x02 PP: next state ADDR, then PP_DATA. If wel = 0, the command is treated as ignored.
  - Any other opcode: IGNORE.
- While wip = 1, every opcode except 0x05 goes to IGNORE. last_cmd is still updated.
- ADDR: collect 24 bits. The low ADDR_WIDTH bits form addr; the upper bits are discarded.
- RD_DATA: output mem[addr] MSB first. addr increments after each byte and wraps modulo 2^ADDR_WIDTH.
- PP_DATA: on each completed byte, mem[addr] <= mem[addr] & byte (programming only clears bits). Then addr[7:0] increments with page wrap; addr[ADDR_WIDTH-1:8] is unchanged.
- PP completion: at csb rise after at least one full PP data byte, clear wel, set wip, and load a counter with PROG_CYCLES. wip clears when the counter reaches 0. A PP with zero data bytes leaves wel set and wip clear.
- Memory contents are not affected by reset. The array initializes to 0xFF at time 0.

## Timing
- Reset values: miso=0, miso_oe=0, wel=0, wip=0, last_cmd=8'h00, state IDLE, counters 0.
- Pin to action: an edge is acted on 3 ifclk cycles after the pin transition (2 sync stages + edge register).
- miso updates 1 ifclk cycle after a detected sclk fall. The first data bit is driven on the fall that follows the last command or address rise.
- The memory read is issued on that last rise. It must be ready by the following fall, so one cycle of memory read latency is allowed.
- miso_oe rises together with the first data bit. It falls 1 cycle after the detected csb rise; miso=0 whenever miso_oe=0.
- Constraint on the master: sclk high time and low time are each ≥ 6 ifclk cycles, and csb low to first sclk rise is ≥ 6 cycles. Behaviour is undefined below this.
- PP write commit happens 1 cycle after the 8th rise of the byte. A simultaneous csb rise and 8th rise (same detection cycle) counts as abort: the byte is not written.
- The wip counter decrements every ifclk cycle. wip is high for exactly PROG_CYCLES cycles starting 1 cycle after the detected csb rise.

## Test plan
- RDID: csb low, send 0x9F, clock 4 bytes -> miso returns 0x20, 0xBA, 0x18, 0x00; last_cmd=0x9F.
- PP without WREN: send 0x02, addr 0x000010, data 0x00 -> mem unchanged. READ at 0x10 returns 0xFF; wel=0, wip=0.
- WREN then PP: send 0x06; then 0x02, addr 0x0000FE, data 0x12, 0x34, 0x56 -> reads return mem[0xFE]=0x12, mem[0xFF]=0x34, mem[0x00]=0x56 (page wrap). wel=0; wip high for PROG_CYCLES cycles.
- RDSR during program: poll 0x05 immediately after PP -> 0x01 until the counter expires, then 0x00. A READ issued while wip=1 returns miso_oe=0 and miso=0.
- Program AND semantics: program 0xF0 then 0x3C at the same address -> read returns 0x30.
- Abort and wrap: READ at addr 2^ADDR_WIDTH-1 with 2 bytes -> returns the last byte, then mem[0]. A csb rise mid-byte during PP leaves that byte unwritten; reset asserted mid-PP clears wel/wip/miso_oe but preserves memory.
